ibex_crash_dump_capture: RTL and testbench
==========================================

Name: ibex_crash_dump_capture

Overview:
- Sits directly downstream of the core's crash_dump output.
- Snapshots the crash_dump_t record, along with the trigger cause and a cycle timestamp, whenever a safety or alert trigger rises.
- Buffers snapshots in a small FIFO for later software or debug readout.
- Exposes the head snapshot through a 32-bit word-addressed read port with a request/valid handshake.

Parameters:
- Depth, 2: number of snapshots held; must be a power of two, 1..8.
- NumTrig, 4: number of trigger inputs, 1..16.
- DropCntW, 8: width of the saturating dropped-event counter; must be ≤ 12.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- crash_dump_i  in  160  crash_dump_t from core: current_pc, next_pc, last_data_addr, exception_pc, exception_addr.
- trig_i  in  NumTrig  level trigger sources (alerts, BIST fail, double fault).
- rd_req_i  in  1  read request.
- rd_addr_i  in  3  word index.
- rd_gnt_o  out  1  request accepted.
- rd_rvalid_o  out  1  read data valid.
- rd_rdata_o  out  32  read data.
- rd_err_o  out  1  read error, qualified by rd_rvalid_o.
- pop_i  in  1  discard head snapshot.
- clear_i  in  1  flush all state except the timestamp.
- pending_o  out  1  FIFO not empty.
- overflow_o  out  1  sticky; at least one snapshot dropped.

Behaviour:
- Reset: all outputs 0. FIFO empty, pointers 0, overflow 0, drop count 0, timestamp 0, trig_q 0, read FSM in IDLE.
- Timestamp: 32-bit free-running counter, +1 per cycle, wraps at 0xFFFFFFFF→0. Not affected by clear_i.
- Trigger detect: trig_q registers trig_i every cycle. rise = trig_i & ~trig_q. Event = |rise.
  - A level held high produces exactly one event.
  - Multiple bits rising in the same cycle give one event, with all risen bits recorded in the cause.
- Capture: on an event in cycle N, the snapshot {crash_dump_i, cause=rise, timestamp} is sampled at the clock edge ending cycle N. Snapshot is visible on read words and pending_o from cycle N+1.
- FIFO rules:
  - Event with FIFO not full → push.
  - Event with FIFO full and no pop → snapshot dropped; overflow set; drop count +1, saturating at all-ones.
  - Event with FIFO full and pop_i in the same cycle → pop, then push accepted; no drop.
  - pop_i with FIFO empty → ignored.
  - Pointer wrap: mod Depth. Occupancy counter is 0..Depth (width $clog2(Depth)+1).
- clear_i has priority over push and pop in the same cycle. It empties the FIFO and clears overflow and drop count. A trigger rising in the same cycle is discarded, but trig_q still updates.
- Read word map (always the head entry):
  - 0: current_pc
  - 1: next_pc
  - 2: last_data_addr
  - 3: exception_pc
  - 4: exception_addr
  - 5: cause, zero-extended
  - 6: timestamp
  - 7: status = {occupancy[3:0] at [31:28], overflow at [27], zeros, drop count at [DropCntW-1:0]}
- Read FSM, two states:
  - IDLE: rd_gnt_o = rd_req_i, combinational. On grant, latch the word and go to RESP.
  - RESP: rd_rvalid_o = 1 for exactly one cycle with registered data; rd_gnt_o = 0; return to IDLE.
  - Sustained throughput is one read every 2 cycles.
- Read data is captured at the grant edge. A pop or clear in the grant cycle does not alter the already-latched response.
- Read of words 0-6 with FIFO empty → rd_rdata_o = 0, rd_err_o = 1. Word 7 never errors.
- pending_o and overflow_o are driven directly from flops. No combinational path from trig_i.
- Reset asserted mid-operation: immediate return to reset state. An in-flight read response is lost; rd_rvalid_o goes to 0 asynchronously.

Decomposition:
- Shared package (ibex_pkg) additions:
  - crash_snap_t packed struct {crash_dump_t dump; logic [15:0] cause; logic [31:0] ts}.
  - crash_word_e enum with the eight word indices.
  - status-word bit-position localparams.
- Sub-module ibex_crash_snap_fifo: parameterised Depth, crash_snap_t storage, push/pop/clear, full/empty/occupancy, simultaneous push+pop-when-full rule.
- Top-level logic: edge detect, timestamp, drop accounting, read FSM, word mux.

Test Plan:
- Reset release, no triggers; read word 7 → rdata 0x00000000, err 0. Read word 0 → rdata 0, err 1, pending_o 0.
- crash_dump_i.current_pc = 0x00001000, trig_i = 0b0100 rising at timestamp 0x25, held high 10 cycles → exactly one snapshot.
  - Word 0 = 0x00001000, word 5 = 0x4, word 6 = 0x25.
  - Word 7 [31:28] = 1; pending_o rises the cycle after the trigger.
- Depth = 2: three distinct rising triggers, no pop → occupancy 2, overflow_o 1, drop count 1. Head is the first snapshot. After two pops, pending_o is 0.
- FIFO full, trigger rise and pop_i in the same cycle → no drop, overflow_o stays 0, occupancy stays 2, new tail holds the latest cause.
- clear_i coincident with a trigger rise and pop_i → occupancy 0, overflow 0, drop count 0, no capture. The timestamp keeps counting.
- Back-to-back rd_req_i held high for 4 cycles → grants in cycles 0 and 2, rvalid in cycles 1 and 3. Reset asserted during RESP → rd_rvalid_o drops immediately and all state returns to reset values.

Source files
------------

// File: rtl/ibex_crash_dump_capture_pkg.sv
// ibex_crash_dump_capture_pkg: shared types for crash snapshot capture
package ibex_crash_dump_capture_pkg;
  typedef struct packed {
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic [31:0] last_data_addr;
    logic [31:0] exception_pc;
    logic [31:0] exception_addr;
  } crash_dump_t;
  typedef struct packed {
    crash_dump_t dump;
    logic [15:0] cause;
    logic [31:0] ts;
  } crash_snap_t;
  typedef enum logic [2:0] {
    W_CUR_PC, W_NEXT_PC, W_LAST_DADDR, W_EXC_PC, W_EXC_ADDR, W_CAUSE, W_TS, W_STATUS
  } crash_word_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
  localparam int unsigned StatOccLsb = 28;
  localparam int unsigned StatOvfBit = 27;
endpackage

// File: rtl/ibex_crash_dump_capture_snap_fifo.sv
// ibex_crash_snap_fifo: snapshot FIFO; a pop frees room for a same-cycle push when full
module ibex_crash_snap_fifo
  import ibex_crash_dump_capture_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  crash_snap_t                data_i,
  output crash_snap_t                head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     occ_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned OccW = $clog2(Depth) + 1;
  crash_snap_t mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic do_push, do_pop;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = occ_q == '0;
  assign full_o  = occ_q == OccW'(Depth);
  assign occ_o   = occ_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o & ~clear_i;
  assign do_push = push_i & ~clear_i & (~full_o | do_pop);
  // pointer and occupancy next state; clear wins over push and pop
  always_comb begin
    wr_d  = clear_i ? '0 : do_push ? inc(wr_q) : wr_q;
    rd_d  = clear_i ? '0 : do_pop ? inc(rd_q) : rd_q;
    occ_d = clear_i ? '0 : occ_q + OccW'(do_push) - OccW'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end
  // storage needs no reset; empty entries are never exposed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ibex_crash_dump_capture.sv
// ibex_crash_dump_capture: snapshots crash_dump on trigger edges and serves them over a read port
module ibex_crash_dump_capture
  import ibex_crash_dump_capture_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter int unsigned NumTrig  = 4,
  parameter int unsigned DropCntW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [159:0]       crash_dump_i,
  input  logic [NumTrig-1:0] trig_i,
  input  logic               rd_req_i,
  input  logic [2:0]         rd_addr_i,
  output logic               rd_gnt_o,
  output logic               rd_rvalid_o,
  output logic [31:0]        rd_rdata_o,
  output logic               rd_err_o,
  input  logic               pop_i,
  input  logic               clear_i,
  output logic               pending_o,
  output logic               overflow_o
);
  localparam int unsigned OccW = $clog2(Depth) + 1;
  logic [NumTrig-1:0]  trig_q, rise;
  logic [31:0]         ts_q;
  logic                ev, full, empty, drop, ovf_q, ovf_d, rd_err_q, err_w;
  logic [DropCntW-1:0] drop_q, drop_d;
  logic [OccW-1:0]     occ;
  crash_snap_t         snap, head;
  crash_dump_t         hd;
  rd_state_e           state_q, state_d;
  logic [31:0]         word, status, data_w, rd_rdata_q;
  assign rise = trig_i & ~trig_q;
  assign ev   = |rise;
  assign snap = '{dump: crash_dump_t'(crash_dump_i), cause: 16'(rise), ts: ts_q};
  assign drop = ev & full & ~pop_i & ~clear_i;
  assign hd   = head.dump;
  ibex_crash_snap_fifo #(.Depth(Depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (ev),
    .pop_i   (pop_i),
    .data_i  (snap),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .occ_o   (occ)
  );
  // sticky overflow and saturating drop counter, both flushed by clear
  always_comb begin
    ovf_d  = clear_i ? 1'b0 : ovf_q | drop;
    drop_d = clear_i ? '0 : (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  // head word selection; empty FIFO reads as an error except for status
  always_comb begin
    status = 32'(drop_q) | (32'(4'(occ)) << StatOccLsb) | (32'(ovf_q) << StatOvfBit);
    word = '0;
    case (crash_word_e'(rd_addr_i))
      W_CUR_PC:     word = hd.current_pc;
      W_NEXT_PC:    word = hd.next_pc;
      W_LAST_DADDR: word = hd.last_data_addr;
      W_EXC_PC:     word = hd.exception_pc;
      W_EXC_ADDR:   word = hd.exception_addr;
      W_CAUSE:      word = 32'(head.cause);
      W_TS:         word = head.ts;
      W_STATUS:     word = status;
      default:      word = '0;
    endcase
    err_w  = empty & (crash_word_e'(rd_addr_i) != W_STATUS);
    data_w = err_w ? '0 : word;
  end
  // read FSM: grant only in idle, respond exactly one cycle later
  always_comb begin
    rd_gnt_o = (state_q == RD_IDLE) & rd_req_i;
    state_d  = rd_gnt_o ? RD_RESP : RD_IDLE;
  end
  // state, trigger history, timestamp, accounting and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RD_IDLE;
      trig_q     <= '0;
      ts_q       <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
      rd_rdata_q <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_i;
      ts_q    <= ts_q + 32'd1;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      if (rd_gnt_o) begin
        rd_rdata_q <= data_w;
        rd_err_q   <= err_w;
      end
    end
  end
  assign rd_rvalid_o = state_q == RD_RESP;
  assign rd_rdata_o  = rd_rdata_q;
  assign rd_err_o    = rd_rvalid_o & rd_err_q;
  assign pending_o   = ~empty;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_ibex_crash_dump_capture.sv
// tb_ibex_crash_dump_capture: directed self-checking bench for the crash snapshot capture block
module tb_ibex_crash_dump_capture;
  logic clk = 1'b0;
  logic rst;
  logic [159:0] cd;
  logic [3:0] trig;
  logic req, gnt, rvalid, err, pop, clr, pending, ovf;
  logic [2:0] addr;
  logic [31:0] rdata, ts_m, t1, t4, tsx, tdummy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic        err;
  } rvec_t;
  rvec_t tv [8];
  ibex_crash_dump_capture dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .crash_dump_i (cd),
    .trig_i       (trig),
    .rd_req_i     (req),
    .rd_addr_i    (addr),
    .rd_gnt_o     (gnt),
    .rd_rvalid_o  (rvalid),
    .rd_rdata_o   (rdata),
    .rd_err_o     (err),
    .pop_i        (pop),
    .clear_i      (clr),
    .pending_o    (pending),
    .overflow_o   (ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst) ts_m <= 32'd0;
    else ts_m <= ts_m + 32'd1;
  end
  function automatic logic [159:0] mk(input logic [31:0] pc);
    return {pc, pc + 32'h4, pc + 32'h1000, pc + 32'h2000, pc + 32'h3000};
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rchk(input string n, input logic [2:0] a, input logic [31:0] d, input logic e);
    req = 1'b1;
    addr = a;
    #1;
    chk({n, "_gnt"}, 32'(gnt), 32'd1);
    tick;
    req = 1'b0;
    chk({n, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({n, "_data"}, rdata, d);
    chk({n, "_err"}, 32'(err), 32'(e));
    tick;
  endtask
  task automatic fire(input logic [3:0] t, input logic [31:0] pc, output logic [31:0] ts);
    cd = mk(pc);
    trig = t;
    ts = ts_m;
    tick;
    trig = '0;
    tick;
  endtask
  task automatic do_pop;
    pop = 1'b1;
    tick;
    pop = 1'b0;
  endtask
  initial begin
    rst = 1'b1; cd = '0; trig = '0; req = 1'b0; addr = '0; pop = 1'b0; clr = 1'b0;
    tick;
    tick;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    rchk("t1_w7", 3'd7, 32'h0, 1'b0);
    rchk("t1_w0", 3'd0, 32'h0, 1'b1);
    chk("t1_pending", 32'(pending), 0);
    cd = mk(32'h1000);
    for (int g = 0; g < 100 && ts_m < 32'h25; g++) tick;
    chk("t2_ts_align", ts_m, 32'h25);
    trig = 4'b0100;
    #1;
    chk("t2_pend_pre", 32'(pending), 0);
    tick;
    chk("t2_pend_post", 32'(pending), 1);
    repeat (9) tick;
    trig = '0;
    tick;
    tv[0] = '{3'd0, 32'h1000, 1'b0};
    tv[1] = '{3'd1, 32'h1004, 1'b0};
    tv[2] = '{3'd2, 32'h2000, 1'b0};
    tv[3] = '{3'd3, 32'h3000, 1'b0};
    tv[4] = '{3'd4, 32'h4000, 1'b0};
    tv[5] = '{3'd5, 32'h4, 1'b0};
    tv[6] = '{3'd6, 32'h25, 1'b0};
    tv[7] = '{3'd7, 32'h1000_0000, 1'b0};
    for (int i = 0; i < 8; i++) rchk($sformatf("t2_w%0d", i), tv[i].addr, tv[i].data, tv[i].err);
    do_pop;
    chk("t2_pend_after_pop", 32'(pending), 0);
    fire(4'b0001, 32'hA0, t1);
    fire(4'b0010, 32'hB0, tdummy);
    fire(4'b1000, 32'hC0, tdummy);
    chk("t3_ovf", 32'(ovf), 1);
    rchk("t3_w7", 3'd7, 32'h2800_0001, 1'b0);
    rchk("t3_w0", 3'd0, 32'hA0, 1'b0);
    rchk("t3_w5", 3'd5, 32'h1, 1'b0);
    rchk("t3_w6", 3'd6, t1, 1'b0);
    do_pop;
    rchk("t3_w0_b", 3'd0, 32'hB0, 1'b0);
    rchk("t3_w5_b", 3'd5, 32'h2, 1'b0);
    rchk("t3_w7_b", 3'd7, 32'h1800_0001, 1'b0);
    do_pop;
    chk("t3_pending", 32'(pending), 0);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 0);
    rchk("t4_w7_clr", 3'd7, 32'h0, 1'b0);
    fire(4'b0001, 32'hD0, tdummy);
    fire(4'b0010, 32'hE0, tdummy);
    cd = mk(32'hF0);
    trig = 4'b0100;
    pop = 1'b1;
    t4 = ts_m;
    tick;
    trig = '0;
    pop = 1'b0;
    tick;
    chk("t4_ovf", 32'(ovf), 0);
    rchk("t4_w7", 3'd7, 32'h2000_0000, 1'b0);
    rchk("t4_w0", 3'd0, 32'hE0, 1'b0);
    do_pop;
    rchk("t4_w0_tail", 3'd0, 32'hF0, 1'b0);
    rchk("t4_w5_tail", 3'd5, 32'h4, 1'b0);
    rchk("t4_w6_tail", 3'd6, t4, 1'b0);
    fire(4'b0001, 32'h11, tdummy);
    fire(4'b0010, 32'h22, tdummy);
    chk("t5_ovf_pre", 32'(ovf), 1);
    cd = mk(32'h33);
    trig = 4'b1000;
    pop = 1'b1;
    clr = 1'b1;
    tick;
    pop = 1'b0;
    clr = 1'b0;
    chk("t5_pending", 32'(pending), 0);
    chk("t5_ovf", 32'(ovf), 0);
    tick;
    chk("t5_pending_hold", 32'(pending), 0);
    rchk("t5_w7", 3'd7, 32'h0, 1'b0);
    trig = '0;
    tick;
    cd = mk(32'h44);
    tsx = ts_m;
    trig = 4'b0001;
    tick;
    trig = '0;
    tick;
    rchk("t5_w6_ts", 3'd6, tsx, 1'b0);
    rchk("t5_w7_after", 3'd7, 32'h1000_0000, 1'b0);
    addr = 3'd7;
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t6_gnt_c%0d", i), 32'(gnt), 32'(i % 2 == 0));
      chk($sformatf("t6_rvalid_c%0d", i), 32'(rvalid), 32'(i % 2 == 1));
      tick;
    end
    req = 1'b0;
    addr = 3'd0;
    req = 1'b1;
    tick;
    req = 1'b0;
    chk("t6_resp", 32'(rvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", 32'(rvalid), 0);
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_rdata", rdata, 0);
    tick;
    rst = 1'b0;
    chk("t6_post_ovf", 32'(ovf), 0);
    rchk("t6_w7", 3'd7, 32'h0, 1'b0);
    rchk("t6_w0", 3'd0, 32'h0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
